ret_addr_stack: RTL and testbench
=================================

RET_ADDR_STACK -- requirements
Module: ret_addr_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32: number of 10-bit return-address entries, a power of two.
REQ-002 The block SHALL have parameter AW, default 10: address width, equal to the program-counter width.
REQ-003 The block SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port PUSH  input  1  CALL/interrupt: store DIN on top of the stack.
REQ-006 The block SHALL have port POP  input  1  RET/RETI: discard the top entry.
REQ-007 The block SHALL have port DIN  input  AW  return address to push (PC of the next instruction).
REQ-008 The block SHALL have port FROM_STACK  output  AW  current top entry, feeding the program-counter mux.
REQ-009 The block SHALL have port EMPTY  output  1  high when the count is 0.
REQ-010 The block SHALL have port FULL  output  1  high when the count equals DEPTH.
REQ-011 The block SHALL have port COUNT  output  clog2(DEPTH)+1  number of valid entries.
REQ-012 The block SHALL have port ERR  output  1  sticky flag for overflow or underflow.

Function
REQ-013 FROM_STACK SHALL be a combinational read of the current top entry, so the program counter can load it on the same edge that POP takes effect.
REQ-014 FROM_STACK SHALL be 0 when EMPTY is high.
REQ-015 On PUSH=1, POP=0 and not FULL, the block SHALL write DIN to entry[COUNT] and increment COUNT at the edge; latency is one cycle.
REQ-016 On POP=1, PUSH=0 and not EMPTY, the block SHALL decrement COUNT at the edge; entry contents are not cleared.
REQ-017 On PUSH=1, POP=1 and not EMPTY, the block SHALL overwrite the top entry with DIN and leave COUNT unchanged.
REQ-018 On PUSH=1, POP=1 and EMPTY, the block SHALL perform the push only and SHALL NOT set ERR.
REQ-019 On PUSH=1 while FULL (without POP), the block SHALL drop the write, hold COUNT at DEPTH and set ERR.
REQ-020 On POP=1 while EMPTY (without PUSH), the block SHALL hold COUNT at 0 and set ERR.
REQ-021 Once set, ERR SHALL remain high until RST.
REQ-022 COUNT SHALL never wrap: it saturates at 0 and at DEPTH.
REQ-023 EMPTY and FULL SHALL be decoded from the registered COUNT, with no extra cycle of latency.

Reset
REQ-024 When RST=1 at a rising edge, the block SHALL set COUNT=0 and ERR=0, giving EMPTY=1, FULL=0 and FROM_STACK=0.
REQ-025 RST SHALL take precedence over a simultaneous PUSH or POP, including mid-sequence.
REQ-026 Entry storage SHALL NOT need reset and SHALL be mappable to distributed RAM.

Structure
REQ-027 AW, DEPTH and the count-width constant SHALL live in the shared rat_pkg package, alongside the PC mux select encodings.
REQ-028 Pointer/count logic SHALL be a sub-module named stack_ptr: an up/down counter with saturation and flag outputs.
REQ-029 Storage and read/write decode SHALL be in ret_addr_stack itself.

Verification
REQ-030 Reset, then PUSH DIN=0x015 for one cycle -> COUNT=1, FROM_STACK=0x015, EMPTY=0.
REQ-031 Push 0x001, 0x002, 0x003, then POP three times -> FROM_STACK reads 0x003, 0x002, 0x001 on successive cycles, then EMPTY=1 and FROM_STACK=0.
REQ-032 Push 32 values, then push 0x3FF -> FULL=1, COUNT=32, ERR=1, top entry unchanged.
REQ-033 From reset, POP=1 -> COUNT=0, ERR=1; ERR stays 1 until RST.
REQ-034 COUNT=2 with top 0x020; assert PUSH=1, POP=1, DIN=0x044 -> COUNT=2, FROM_STACK=0x044.
REQ-035 COUNT=5; RST=1 together with PUSH=1 -> COUNT=0, EMPTY=1, ERR=0.

Source files
------------

// File: rtl/rat_pkg.sv
// ============================================================================
// rat_pkg : shared constants and encodings for the return-address stack
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package rat_pkg;

   localparam int RAT_AW    = 10;
   localparam int RAT_DEPTH = 32;
   localparam int RAT_CW    = $clog2(RAT_DEPTH) + 1;

   // Program-counter source select, shared with the sequencer's PC mux.
   typedef enum logic [1:0] {
      PC_SEL_INC    = 2'd0,
      PC_SEL_BRANCH = 2'd1,
      PC_SEL_STACK  = 2'd2,
      PC_SEL_VECTOR = 2'd3
   } pc_sel_e;

   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stack_ptr.sv
// ============================================================================
// stack_ptr : saturating up/down entry counter with empty/full/sticky-error
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module stack_ptr
   import rat_pkg::*;
#(
   parameter int DEPTH = RAT_DEPTH,
   parameter int CW    = cnt_width(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o,
   output logic          err_o
);

   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign err_o   = err_q;

   always_comb begin
      count_d = count_q;
      err_d   = err_q;
      if (push_i && pop_i) begin
         // Simultaneous push/pop is a replace; on an empty stack it degrades to a push.
         if (empty_o) begin
            count_d = count_q + CW'(1);
         end
      end else if (push_i) begin
         if (full_o) begin
            err_d = 1'b1;
         end else begin
            count_d = count_q + CW'(1);
         end
      end else if (pop_i) begin
         if (empty_o) begin
            err_d = 1'b1;
         end else begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ret_addr_stack.sv
// ============================================================================
// ret_addr_stack : CALL/RET return-address LIFO with combinational top read
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ret_addr_stack
   import rat_pkg::*;
#(
   parameter int DEPTH = RAT_DEPTH,
   parameter int AW    = RAT_AW
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        PUSH,
   input  logic                        POP,
   input  logic [AW-1:0]               DIN,
   output logic [AW-1:0]               FROM_STACK,
   output logic                        EMPTY,
   output logic                        FULL,
   output logic [cnt_width(DEPTH)-1:0] COUNT,
   output logic                        ERR
);

   localparam int CW = cnt_width(DEPTH);
   localparam int IW = $clog2(DEPTH);

   logic [AW-1:0] mem_q [DEPTH];

   logic [IW-1:0] w_cnt_lo;
   logic [IW-1:0] w_top_idx;
   logic [IW-1:0] w_wr_idx;
   logic          w_replace;
   logic          w_wr_en;

   stack_ptr #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_ptr (
      .clk_i   (CLK),
      .rst_i   (RST),
      .push_i  (PUSH),
      .pop_i   (POP),
      .count_o (COUNT),
      .empty_o (EMPTY),
      .full_o  (FULL),
      .err_o   (ERR)
   );

   // At COUNT==DEPTH the low bits wrap to 0, so top index still lands on DEPTH-1.
   assign w_cnt_lo  = COUNT[IW-1:0];
   assign w_top_idx = w_cnt_lo - IW'(1);
   assign w_replace = PUSH & POP & ~EMPTY;
   assign w_wr_en   = ~RST & PUSH & (POP | ~FULL);
   assign w_wr_idx  = w_replace ? w_top_idx : w_cnt_lo;

   always_ff @(posedge CLK) begin
      if (w_wr_en) begin
         mem_q[w_wr_idx] <= DIN;
      end
   end

   assign FROM_STACK = EMPTY ? '0 : mem_q[w_top_idx];

endmodule

`default_nettype wire

// File: tb/tb_ret_addr_stack.sv
// ============================================================================
// tb_ret_addr_stack : vector table, corner sequences and random vs. LIFO model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_ret_addr_stack;

   localparam int DEPTH = 32;
   localparam int AW    = 10;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          PUSH = 1'b0;
   logic          POP = 1'b0;
   logic [AW-1:0] DIN = '0;
   logic [AW-1:0] FROM_STACK;
   logic          EMPTY;
   logic          FULL;
   logic [CW-1:0] COUNT;
   logic          ERR;

   ret_addr_stack #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .PUSH       (PUSH),
      .POP        (POP),
      .DIN        (DIN),
      .FROM_STACK (FROM_STACK),
      .EMPTY      (EMPTY),
      .FULL       (FULL),
      .COUNT      (COUNT),
      .ERR        (ERR)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: a plain LIFO of return addresses plus a sticky error bit.
   logic [AW-1:0] mdl_q[$];
   bit            mdl_err;

   typedef struct {
      bit            rst;
      bit            push;
      bit            pop;
      logic [AW-1:0] din;
      int            cnt;
      logic [AW-1:0] top;
      bit            err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(bit r, bit pu, bit po, int d, int c, int t, bit e);
      vec_t x;
      x.rst = r; x.push = pu; x.pop = po; x.din = AW'(d);
      x.cnt = c; x.top = AW'(t); x.err = e;
      return x;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit pu, input bit po, input logic [AW-1:0] d);
      if (r) begin
         mdl_q.delete();
         mdl_err = 1'b0;
      end else if (pu && po) begin
         if (mdl_q.size() == 0) mdl_q.push_back(d);
         else                   mdl_q[$] = d;
      end else if (pu) begin
         if (mdl_q.size() == DEPTH) mdl_err = 1'b1;
         else                       mdl_q.push_back(d);
      end else if (po) begin
         if (mdl_q.size() == 0) mdl_err = 1'b1;
         else                   void'(mdl_q.pop_back());
      end
   endtask

   // Drive on the falling edge, let the rising edge act, observe 1ns later.
   task automatic apply(input bit r, input bit pu, input bit po, input logic [AW-1:0] d);
      @(negedge CLK);
      RST = r; PUSH = pu; POP = po; DIN = d;
      @(posedge CLK);
      #1;
      model_step(r, pu, po, d);
      RST = 1'b0; PUSH = 1'b0; POP = 1'b0;
   endtask

   task automatic chk_expect(input string tag, input int c, input int t, input bit e);
      chk({tag, ".count"}, int'(COUNT), c);
      chk({tag, ".top"},   int'(FROM_STACK), t);
      chk({tag, ".empty"}, int'(EMPTY), int'(c == 0));
      chk({tag, ".full"},  int'(FULL), int'(c == DEPTH));
      chk({tag, ".err"},   int'(ERR), int'(e));
   endtask

   task automatic chk_model(input string tag);
      chk_expect(tag, mdl_q.size(), (mdl_q.size() == 0) ? 0 : int'(mdl_q[$]), mdl_err);
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin : main
      int last_val;
      int pr;

      // Hand-derived vectors: {rst, push, pop, din} -> {count, top, err}
      vecs.push_back(v(1,0,0,'h000, 0,'h000,0));
      vecs.push_back(v(0,1,0,'h015, 1,'h015,0));
      vecs.push_back(v(1,0,0,'h000, 0,'h000,0));
      vecs.push_back(v(0,1,0,'h001, 1,'h001,0));
      vecs.push_back(v(0,1,0,'h002, 2,'h002,0));
      vecs.push_back(v(0,1,0,'h003, 3,'h003,0));
      vecs.push_back(v(0,0,1,'h000, 2,'h002,0));
      vecs.push_back(v(0,0,1,'h000, 1,'h001,0));
      vecs.push_back(v(0,0,1,'h000, 0,'h000,0));
      vecs.push_back(v(0,0,1,'h000, 0,'h000,1));
      vecs.push_back(v(0,0,0,'h000, 0,'h000,1));
      vecs.push_back(v(0,1,0,'h020, 1,'h020,1));
      vecs.push_back(v(1,0,0,'h000, 0,'h000,0));
      vecs.push_back(v(0,1,0,'h010, 1,'h010,0));
      vecs.push_back(v(0,1,0,'h020, 2,'h020,0));
      vecs.push_back(v(0,1,1,'h044, 2,'h044,0));
      vecs.push_back(v(0,0,1,'h000, 1,'h010,0));
      vecs.push_back(v(0,0,1,'h000, 0,'h000,0));
      vecs.push_back(v(0,1,1,'h077, 1,'h077,0));
      vecs.push_back(v(0,1,0,'h101, 2,'h101,0));
      vecs.push_back(v(0,1,0,'h102, 3,'h102,0));
      vecs.push_back(v(0,1,0,'h103, 4,'h103,0));
      vecs.push_back(v(0,1,0,'h104, 5,'h104,0));
      vecs.push_back(v(1,1,0,'h3FF, 0,'h000,0));
      vecs.push_back(v(0,0,0,'h000, 0,'h000,0));

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].din);
         chk_expect($sformatf("vec%0d", i), vecs[i].cnt, int'(vecs[i].top), vecs[i].err);
      end

      // Fill to capacity, then overflow, replace-at-full and pop back.
      apply(1, 0, 0, '0);
      for (int i = 0; i < DEPTH; i++) apply(0, 1, 0, AW'(10'h200 + i));
      last_val = 'h200 + DEPTH - 1;
      chk_expect("fill", DEPTH, last_val, 1'b0);
      apply(0, 1, 0, 10'h3FF);
      chk_expect("overflow", DEPTH, last_val, 1'b1);
      apply(0, 1, 1, 10'h2AA);
      chk_expect("replace_full", DEPTH, 'h2AA, 1'b1);
      apply(0, 0, 1, '0);
      chk_expect("pop_after_full", DEPTH - 1, 'h200 + DEPTH - 2, 1'b1);
      apply(0, 0, 0, '0);
      chk_expect("err_sticky", DEPTH - 1, 'h200 + DEPTH - 2, 1'b1);

      // Randomised traffic; push bias sweeps so both saturation ends are reached.
      apply(1, 0, 0, '0);
      for (int i = 0; i < 3000; i++) begin
         bit r, pu, po;
         pr = ((i / 400) % 2 == 0) ? 75 : 25;
         r  = ($urandom_range(0, 199) == 0);
         pu = ($urandom_range(0, 99) < pr);
         po = ($urandom_range(0, 99) < (100 - pr));
         apply(r, pu, po, AW'($urandom));
         chk_model($sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
